// File: rtl/bf_pkg.sv
// Shared definitions for the bf I/O bridge: CPU transfer direction encoding and bridge FSM states.
package bf_pkg;

    localparam logic BF_DIR_READ  = 1'b0;
    localparam logic BF_DIR_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } bf_state_t;

endpackage

// File: rtl/bf_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; push/pop take effect on the clock edge, dout shows the head combinationally.
// Push is ignored when full and pop is ignored when empty; storage is not reset, so use empty to mask dout.
module bf_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_din,
    output logic [7:0] o_dout,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    // The extra MSB on each pointer tells full apart from empty when the addresses match.
    assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/bf_io_bridge.sv
// Bridges the CPU io_req/io_ack port to host byte streams through TX and RX FIFOs; ack one cycle after acceptance.
// Writes stall only while TX is full, reads only while RX is empty (BF_IO_EOF_EN: reads at EOF return EOF_VALUE).
module bf_io_bridge
    import bf_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] EOF_VALUE  = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       io_req,
    input  logic       io_dir,
    input  logic [7:0] io_wdata,
    output logic       io_ack,
    output logic [7:0] io_rdata,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       in_eof
);

    bf_state_t  r_state;
    logic       r_ack;
    logic [7:0] r_rdata;

    logic       w_idle_req;
    logic       w_tx_push;
    logic       w_tx_pop;
    logic       w_tx_full;
    logic       w_tx_empty;
    logic       w_rx_push;
    logic       w_rx_pop;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic [7:0] w_rx_dout;
    logic       w_eof_go;

    assign w_idle_req = (r_state == ST_IDLE) && io_req;
    assign w_tx_push  = w_idle_req && (io_dir == BF_DIR_WRITE) && !w_tx_full;
    assign w_rx_pop   = w_idle_req && (io_dir == BF_DIR_READ) && !w_rx_empty;
    assign w_tx_pop   = out_valid && out_ready;
    assign w_rx_push  = in_valid && in_ready;

`ifdef BF_IO_EOF_EN
    // Buffered host data always drains before EOF is reported.
    assign w_eof_go = w_idle_req && (io_dir == BF_DIR_READ) && w_rx_empty && in_eof;
`else
    assign w_eof_go = in_eof & 1'b0;
`endif

    assign io_ack    = r_ack;
    assign io_rdata  = r_rdata;
    assign out_valid = !w_tx_empty;
    assign in_ready  = !w_rx_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= 1'b0;
                    if (w_tx_push) begin
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK;
                    end else if (w_rx_pop || w_eof_go) begin
                        r_rdata <= w_eof_go ? EOF_VALUE : w_rx_dout;
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_ack   <= 1'b0;
                    r_state <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    r_ack <= 1'b0;
                    if (!io_req) r_state <= ST_IDLE;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    bf_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_tx_push),
        .i_pop   (w_tx_pop),
        .i_din   (io_wdata),
        .o_dout  (out_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    bf_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rx_push),
        .i_pop   (w_rx_pop),
        .i_din   (in_data),
        .o_dout  (w_rx_dout),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

endmodule

// File: tb/tb_bf_io_bridge.sv
// Scoreboard bench for bf_io_bridge: directed CPU/host traffic, expectations queued at issue, checked by a monitor.
module tb_bf_io_bridge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       io_req;
    logic       io_dir;
    logic [7:0] io_wdata;
    logic       io_ack;
    logic [7:0] io_rdata;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       in_eof;

    typedef struct {
        bit       is_read;
        bit [7:0] data;
    } ack_exp_t;

    ack_exp_t   exp_ack[$];
    bit [7:0]   exp_out[$];
    int         checks = 0;
    int         errors = 0;
    int         ack_cnt = 0;
    bit         prev_ack = 1'b0;

    bf_io_bridge #(.FIFO_DEPTH(4), .EOF_VALUE(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io_req    (io_req),
        .io_dir    (io_dir),
        .io_wdata  (io_wdata),
        .io_ack    (io_ack),
        .io_rdata  (io_rdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .in_eof    (in_eof)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every host-side pop and every CPU ack is matched against the queued expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    chk("out_unexpected", 1, 0);
                end else begin
                    chk("out_data", int'(out_data), int'(exp_out.pop_front()));
                end
            end
            if (io_ack) begin
                ack_exp_t e;
                ack_cnt++;
                chk("ack_single_cycle", int'(prev_ack), 0);
                if (exp_ack.size() == 0) begin
                    chk("ack_unexpected", 1, 0);
                end else begin
                    e = exp_ack.pop_front();
                    if (e.is_read) chk("io_rdata", int'(io_rdata), int'(e.data));
                end
            end
        end
        prev_ack = io_ack;
    end

    task automatic cpu_issue(input bit dir, input bit [7:0] wdata, input bit [7:0] rexp, input bit track_out);
        ack_exp_t e;
        e.is_read = (dir == 1'b0);
        e.data    = rexp;
        exp_ack.push_back(e);
        if (dir && track_out) exp_out.push_back(wdata);
        @(posedge clk); #1;
        io_req   = 1'b1;
        io_dir   = dir;
        io_wdata = wdata;
    endtask

    // Counts negedges until io_ack is seen; an expired budget counts as a failure.
    task automatic cpu_wait_ack(input int budget, output int lat);
        bit seen = 1'b0;
        lat = 0;
        while (!seen && lat < budget) begin
            @(negedge clk);
            lat++;
            if (io_ack) seen = 1'b1;
        end
        if (!seen) chk("ack_timeout", 0, 1);
    endtask

    task automatic cpu_drop();
        @(posedge clk); #1;
        io_req = 1'b0;
    endtask

    task automatic cpu_xfer(input bit dir, input bit [7:0] wdata, input bit [7:0] rexp, input bit track_out);
        int lat;
        cpu_issue(dir, wdata, rexp, track_out);
        cpu_wait_ack(20, lat);
        cpu_drop();
    endtask

    task automatic host_push(input bit [7:0] d);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int a0;
        rst_n     = 1'b0;
        io_req    = 1'b0;
        io_dir    = 1'b0;
        io_wdata  = 8'h00;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_eof    = 1'b0;
        idle(2);
        chk("rst_io_ack", int'(io_ack), 0);
        chk("rst_io_rdata", int'(io_rdata), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        idle(2);

        // Single write: req raised before edge N, ack visible at the negedge after N (second negedge waited).
        out_ready = 1'b1;
        cpu_issue(1'b1, 8'h41, 8'h00, 1'b1);
        cpu_wait_ack(20, lat);
        chk("write_ack_latency", lat, 2);
        cpu_drop();
        @(negedge clk);
        chk("out_valid_after_pop", int'(out_valid), 0);
        idle(2);

        // Fill TX (depth 4) with the host stalled; the fifth write must wait for a pop.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) cpu_xfer(1'b1, 8'hA0 + 8'(i), 8'h00, 1'b1);
        idle(1);
        a0 = ack_cnt;
        cpu_issue(1'b1, 8'hA4, 8'h00, 1'b1);
        idle(6);
        chk("tx_full_stall", ack_cnt, a0);
        out_ready = 1'b1;
        cpu_wait_ack(20, lat);
        chk("tx_full_resume_latency", lat, 3);
        cpu_drop();
        idle(8);
        chk("tx_drained", exp_out.size(), 0);

        // Host bytes come back to the CPU in order.
        host_push(8'h10);
        host_push(8'h20);
        cpu_xfer(1'b0, 8'h00, 8'h10, 1'b0);
        cpu_xfer(1'b0, 8'h00, 8'h20, 1'b0);
        idle(2);

        in_eof = 1'b1;
`ifdef BF_IO_EOF_EN
        cpu_xfer(1'b0, 8'h00, 8'h00, 1'b0);
`else
        a0 = ack_cnt;
        cpu_issue(1'b0, 8'h00, 8'h33, 1'b0);
        idle(8);
        chk("eof_ignored_stall", ack_cnt, a0);
        host_push(8'h33);
        cpu_wait_ack(20, lat);
        cpu_drop();
`endif
        idle(2);
        // Buffered data wins over EOF.
        host_push(8'h55);
        cpu_xfer(1'b0, 8'h00, 8'h55, 1'b0);
        in_eof = 1'b0;
        idle(2);

        // Request held high long after ack: one ack, one push.
        out_ready = 1'b0;
        a0 = ack_cnt;
        cpu_issue(1'b1, 8'h77, 8'h00, 1'b1);
        cpu_wait_ack(20, lat);
        idle(5);
        io_req = 1'b0;
        idle(3);
        chk("held_req_one_ack", ack_cnt, a0 + 1);
        out_ready = 1'b1;
        idle(4);
        chk("held_req_one_push", exp_out.size(), 0);
        chk("held_req_tx_empty", int'(out_valid), 0);

        // Reset during the ACK cycle with two bytes parked in TX.
        out_ready = 1'b0;
        cpu_xfer(1'b1, 8'hB1, 8'h00, 1'b0);
        cpu_xfer(1'b1, 8'hB2, 8'h00, 1'b0);
        cpu_issue(1'b1, 8'hB3, 8'h00, 1'b0);
        cpu_wait_ack(20, lat);
        #2;
        rst_n  = 1'b0;
        io_req = 1'b0;
        #1;
        chk("midrst_io_ack", int'(io_ack), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_io_rdata", int'(io_rdata), 0);
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(4);
        chk("post_rst_tx_empty", int'(out_valid), 0);

        chk("ack_queue_empty", exp_ack.size(), 0);
        chk("out_queue_empty", exp_out.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
